cpu_cu: RTL and testbench

//  Control unit for the RISC16 CPU; sits directly upstream of CPU_EU and drives its control strobes.

---
 rtl/cpu_cu_if.sv | 41 ++++
 rtl/cpu_cu.sv | 175 +++++++++++++++++
 tb/tb_cpu_cu.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_cu_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_cu_if
//  Description : Control/status bundle between the RISC16 control unit and
//                the execution unit / memory side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cpu_cu_if #(
    parameter int DW = 16
);
    logic [DW-1:0] ir;
    logic          zero;
    logic          neg;
    logic          mem_ready;
    logic          ir_ld;
    logic          pc_inc;
    logic          pc_ld;
    logic          we;
    logic          s_sel;
    logic          addr_sel;
    logic          mem_rd;
    logic          mem_wr;
    logic [3:0]    alu_op;
    logic          halted;
    logic          bus_err;
    logic          illegal;
    logic [15:0]   retire_cnt;

    modport master (
        input  ir, zero, neg, mem_ready,
        output ir_ld, pc_inc, pc_ld, we, s_sel, addr_sel, mem_rd, mem_wr,
               alu_op, halted, bus_err, illegal, retire_cnt
    );

    modport slave (
        output ir, zero, neg, mem_ready,
        input  ir_ld, pc_inc, pc_ld, we, s_sel, addr_sel, mem_rd, mem_wr,
               alu_op, halted, bus_err, illegal, retire_cnt
    );
endinterface
`default_nettype wire

// File: rtl/cpu_cu.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_cu
//  Description : RISC16 control unit - fetch/decode/execute/memory sequencer
//                with memory handshake, bus timeout and retire counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_cu #(
    parameter int DW      = 16,
    parameter int TIMEOUT = 15
) (
    input  wire logic clk,
    input  wire logic rst,
    cpu_cu_if.master  bus
);
    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM_RD = 3'd4,
        S_MEM_WR = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [3:0] c_OP_NOP = 4'h0;
    localparam logic [3:0] c_OP_SHR = 4'h8;
    localparam logic [3:0] c_OP_LD  = 4'h9;
    localparam logic [3:0] c_OP_ST  = 4'hA;
    localparam logic [3:0] c_OP_JMP = 4'hB;
    localparam logic [3:0] c_OP_BZ  = 4'hC;
    localparam logic [3:0] c_OP_BN  = 4'hD;
    localparam logic [3:0] c_OP_RSV = 4'hE;
    localparam logic [3:0] c_OP_HLT = 4'hF;
    // Last wait-cycle index: a miss here means TIMEOUT cycles have gone unanswered.
    localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_wait;
    logic [15:0] r_retire_cnt;
    logic        r_bus_err;
    logic        w_retire;
    logic        w_timeout;
    logic [3:0]  w_opcode;
    logic        w_wait_state;
    logic        w_unused;

    assign w_opcode     = bus.ir[DW-1 -: 4];
    assign w_unused     = ^bus.ir[DW-5:0];
    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                          (r_state == S_MEM_WR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_RST;
            r_wait       <= 8'd0;
            r_retire_cnt <= 16'd0;
            r_bus_err    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state != r_state)
                r_wait <= 8'd0;
            else if (w_wait_state && !bus.mem_ready)
                r_wait <= r_wait + 8'd1;
            if (w_retire)
                r_retire_cnt <= r_retire_cnt + 16'd1;
            if (w_timeout)
                r_bus_err <= 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_retire     = 1'b0;
        w_timeout    = 1'b0;
        bus.ir_ld    = 1'b0;
        bus.pc_inc   = 1'b0;
        bus.pc_ld    = 1'b0;
        bus.we       = 1'b0;
        bus.s_sel    = 1'b0;
        bus.addr_sel = 1'b0;
        bus.mem_rd   = 1'b0;
        bus.mem_wr   = 1'b0;
        bus.alu_op   = 4'h0;
        bus.illegal  = 1'b0;

        case (r_state)
            S_RST: w_next_state = S_FETCH;

            S_FETCH: begin
                if (bus.mem_ready) begin
                    bus.mem_rd   = 1'b1;
                    bus.ir_ld    = 1'b1;
                    bus.pc_inc   = 1'b1;
                    w_next_state = S_DECODE;
                end else if (r_wait == c_WAIT_LAST) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_HALT;
                end else begin
                    bus.mem_rd   = 1'b1;
                end
            end

            S_DECODE: begin
                case (w_opcode)
                    c_OP_LD:  w_next_state = S_MEM_RD;
                    c_OP_ST:  w_next_state = S_MEM_WR;
                    c_OP_HLT: begin
                        w_next_state = S_HALT;
                        w_retire     = 1'b1;
                    end
                    default:  w_next_state = S_EXEC;
                endcase
            end

            S_EXEC: begin
                bus.alu_op   = w_opcode;
                w_next_state = S_FETCH;
                w_retire     = 1'b1;
                if (w_opcode != c_OP_NOP && w_opcode <= c_OP_SHR)
                    bus.we = 1'b1;
                case (w_opcode)
                    c_OP_JMP: bus.pc_ld   = 1'b1;
                    c_OP_BZ:  bus.pc_ld   = bus.zero;
                    c_OP_BN:  bus.pc_ld   = bus.neg;
                    c_OP_RSV: bus.illegal = 1'b1;
                    default:  ;
                endcase
            end

            S_MEM_RD: begin
                if (bus.mem_ready) begin
                    bus.addr_sel = 1'b1;
                    bus.mem_rd   = 1'b1;
                    bus.we       = 1'b1;
                    bus.s_sel    = 1'b1;
                    w_retire     = 1'b1;
                    w_next_state = S_FETCH;
                end else if (r_wait == c_WAIT_LAST) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_HALT;
                end else begin
                    bus.addr_sel = 1'b1;
                    bus.mem_rd   = 1'b1;
                end
            end

            S_MEM_WR: begin
                if (bus.mem_ready) begin
                    bus.addr_sel = 1'b1;
                    bus.mem_wr   = 1'b1;
                    w_retire     = 1'b1;
                    w_next_state = S_FETCH;
                end else if (r_wait == c_WAIT_LAST) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_HALT;
                end else begin
                    bus.addr_sel = 1'b1;
                    bus.mem_wr   = 1'b1;
                end
            end

            S_HALT:  w_next_state = S_HALT;

            default: w_next_state = S_RST;
        endcase
    end

    assign bus.halted     = (r_state == S_HALT);
    assign bus.bus_err    = r_bus_err;
    assign bus.retire_cnt = r_retire_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cpu_cu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_cu
//  Description : Directed self-checking bench for the RISC16 control unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_cu;
    // Strobe vector order: {ir_ld,pc_inc,pc_ld,we,s_sel,addr_sel,mem_rd,mem_wr,illegal,halted,bus_err}
    localparam logic [10:0] c_IR_LD    = 11'h400;
    localparam logic [10:0] c_PC_INC   = 11'h200;
    localparam logic [10:0] c_PC_LD    = 11'h100;
    localparam logic [10:0] c_WE       = 11'h080;
    localparam logic [10:0] c_S_SEL    = 11'h040;
    localparam logic [10:0] c_ADDR_SEL = 11'h020;
    localparam logic [10:0] c_MEM_RD   = 11'h010;
    localparam logic [10:0] c_MEM_WR   = 11'h008;
    localparam logic [10:0] c_ILLEGAL  = 11'h004;
    localparam logic [10:0] c_HALTED   = 11'h002;
    localparam logic [10:0] c_BUS_ERR  = 11'h001;
    localparam logic [10:0] c_NONE     = 11'h000;
    localparam logic [10:0] c_FETCH_OK = c_IR_LD | c_PC_INC | c_MEM_RD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    cpu_cu_if #(.DW(16)) bus ();

    cpu_cu #(.DW(16), .TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] strobes();
        return {bus.ir_ld, bus.pc_inc, bus.pc_ld, bus.we, bus.s_sel, bus.addr_sel,
                bus.mem_rd, bus.mem_wr, bus.illegal, bus.halted, bus.bus_err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        bus.ir = 16'h1123; bus.zero = 1'b0; bus.neg = 1'b0; bus.mem_ready = 1'b1;
        tick();
        #1;
        checks++;
        if (strobes() !== c_NONE || bus.alu_op !== 4'h0) begin
            errors++; $display("FAIL reset_outputs got %h/%h exp %h/0", strobes(), bus.alu_op, c_NONE);
        end
        checks++;
        if (bus.retire_cnt !== 16'h0000) begin
            errors++; $display("FAIL reset_retire got %h exp 0000", bus.retire_cnt);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (strobes() !== c_NONE) begin
            errors++; $display("FAIL s_rst_idle got %h exp %h", strobes(), c_NONE);
        end
        tick();
    endtask

    task automatic test_alu();
        #1;
        checks++;
        if (strobes() !== c_FETCH_OK) begin
            errors++; $display("FAIL add_fetch got %h exp %h", strobes(), c_FETCH_OK);
        end
        tick();
        #1;
        checks++;
        if (strobes() !== c_NONE || bus.alu_op !== 4'h0) begin
            errors++; $display("FAIL add_decode got %h/%h exp %h/0", strobes(), bus.alu_op, c_NONE);
        end
        tick();
        #1;
        checks++;
        if (strobes() !== c_WE || bus.alu_op !== 4'h1) begin
            errors++; $display("FAIL add_exec got %h/%h exp %h/1", strobes(), bus.alu_op, c_WE);
        end
        tick();
        checks++;
        if (bus.retire_cnt !== 16'h0001) begin
            errors++; $display("FAIL add_retire got %h exp 0001", bus.retire_cnt);
        end
    endtask

    task automatic test_ld_wait();
        bus.ir = 16'h9120;
        tick();
        tick();
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (strobes() !== (c_ADDR_SEL | c_MEM_RD)) begin
                errors++; $display("FAIL ld_wait%0d got %h exp %h", i, strobes(), c_ADDR_SEL | c_MEM_RD);
            end
            tick();
        end
        bus.mem_ready = 1'b1;
        #1;
        checks++;
        if (strobes() !== (c_ADDR_SEL | c_MEM_RD | c_WE | c_S_SEL)) begin
            errors++; $display("FAIL ld_ready got %h exp %h", strobes(), c_ADDR_SEL | c_MEM_RD | c_WE | c_S_SEL);
        end
        tick();
        checks++;
        if (bus.retire_cnt !== 16'h0002) begin
            errors++; $display("FAIL ld_retire got %h exp 0002", bus.retire_cnt);
        end
    endtask

    task automatic test_branch();
        bus.ir = 16'hC100; bus.zero = 1'b0;
        tick();
        tick();
        #1;
        checks++;
        if (strobes() !== c_NONE || bus.alu_op !== 4'hC) begin
            errors++; $display("FAIL bz_not_taken got %h/%h exp %h/c", strobes(), bus.alu_op, c_NONE);
        end
        tick();
        bus.zero = 1'b1;
        tick();
        tick();
        #1;
        checks++;
        if (strobes() !== c_PC_LD) begin
            errors++; $display("FAIL bz_taken got %h exp %h", strobes(), c_PC_LD);
        end
        tick();
        bus.ir = 16'hD000; bus.zero = 1'b0; bus.neg = 1'b1;
        tick();
        tick();
        #1;
        checks++;
        if (strobes() !== c_PC_LD || bus.alu_op !== 4'hD) begin
            errors++; $display("FAIL bn_taken got %h/%h exp %h/d", strobes(), bus.alu_op, c_PC_LD);
        end
        tick();
        bus.neg = 1'b0;
        checks++;
        if (bus.retire_cnt !== 16'h0005) begin
            errors++; $display("FAIL branch_retire got %h exp 0005", bus.retire_cnt);
        end
    endtask

    task automatic test_timeout();
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 14; i++) begin
            #1;
            checks++;
            if (strobes() !== c_MEM_RD) begin
                errors++; $display("FAIL fetch_wait%0d got %h exp %h", i, strobes(), c_MEM_RD);
            end
            tick();
        end
        #1;
        checks++;
        if (strobes() !== c_NONE) begin
            errors++; $display("FAIL timeout_cycle got %h exp %h", strobes(), c_NONE);
        end
        tick();
        #1;
        checks++;
        if (strobes() !== (c_HALTED | c_BUS_ERR) || bus.retire_cnt !== 16'h0005) begin
            errors++; $display("FAIL timeout_halt got %h/%h exp %h/0005", strobes(), bus.retire_cnt, c_HALTED | c_BUS_ERR);
        end
        bus.mem_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (strobes() !== (c_HALTED | c_BUS_ERR)) begin
            errors++; $display("FAIL timeout_sticky got %h exp %h", strobes(), c_HALTED | c_BUS_ERR);
        end
    endtask

    task automatic test_illegal_halt();
        do_reset();
        bus.ir = 16'hE000;
        tick();
        tick();
        #1;
        checks++;
        if (strobes() !== c_ILLEGAL || bus.alu_op !== 4'hE) begin
            errors++; $display("FAIL illegal_exec got %h/%h exp %h/e", strobes(), bus.alu_op, c_ILLEGAL);
        end
        tick();
        #1;
        checks++;
        if (strobes() !== c_FETCH_OK || bus.retire_cnt !== 16'h0001) begin
            errors++; $display("FAIL illegal_pulse got %h/%h exp %h/0001", strobes(), bus.retire_cnt, c_FETCH_OK);
        end
        bus.ir = 16'hF000;
        tick();
        #1;
        checks++;
        if (strobes() !== c_NONE) begin
            errors++; $display("FAIL hlt_decode got %h exp %h", strobes(), c_NONE);
        end
        tick();
        #1;
        checks++;
        if (strobes() !== c_HALTED || bus.retire_cnt !== 16'h0002) begin
            errors++; $display("FAIL hlt_entry got %h/%h exp %h/0002", strobes(), bus.retire_cnt, c_HALTED);
        end
        for (int i = 0; i < 50; i++) begin
            bus.mem_ready = i[0];
            tick();
        end
        bus.mem_ready = 1'b1;
        checks++;
        if (strobes() !== c_HALTED || bus.retire_cnt !== 16'h0002) begin
            errors++; $display("FAIL hlt_hold got %h/%h exp %h/0002", strobes(), bus.retire_cnt, c_HALTED);
        end
    endtask

    task automatic test_reset_mid_wr_and_wrap();
        do_reset();
        bus.ir = 16'h0000;
        repeat (3) tick();
        checks++;
        if (bus.retire_cnt !== 16'h0001) begin
            errors++; $display("FAIL nop_retire got %h exp 0001", bus.retire_cnt);
        end
        bus.ir = 16'hA000;
        tick();
        tick();
        bus.mem_ready = 1'b0;
        #1;
        checks++;
        if (strobes() !== (c_ADDR_SEL | c_MEM_WR)) begin
            errors++; $display("FAIL st_wait got %h exp %h", strobes(), c_ADDR_SEL | c_MEM_WR);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (strobes() !== c_NONE || bus.alu_op !== 4'h0 || bus.retire_cnt !== 16'h0000) begin
            errors++; $display("FAIL rst_mid_wr got %h/%h/%h exp %h/0/0000", strobes(), bus.alu_op, bus.retire_cnt, c_NONE);
        end
        tick();
        rst = 1'b0;
        tick();
        bus.mem_ready = 1'b1;
        bus.ir = 16'h0000;
        force dut.r_retire_cnt = 16'hFFFF;
        #1;
        release dut.r_retire_cnt;
        repeat (3) tick();
        checks++;
        if (bus.retire_cnt !== 16'h0000) begin
            errors++; $display("FAIL retire_wrap got %h exp 0000", bus.retire_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_ld_wait();
        test_branch();
        test_timeout();
        test_illegal_halt();
        test_reset_mid_wr_and_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end
endmodule
`default_nettype wire
